// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, FSM states, iteration default and sign helpers.
package ex_muldiv_pkg;

  localparam int ITER_DEFAULT = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // 0x80000000 maps onto itself, which is exactly 2^31 when read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring-subtract divide. Purely combinational.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [31:0] acc_hi_i,
  input  logic [31:0] acc_lo_i,
  input  logic [31:0] opnd_i,
  output logic [31:0] acc_hi_o,
  output logic [31:0] acc_lo_o
);

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;

  // Multiply: LO holds the remaining multiplier bits, product shifts in from the top.
  assign mul_sum = {1'b0, acc_hi_i} + {1'b0, (acc_lo_i[0] ? opnd_i : 32'd0)};

  // Divide: HI is the partial remainder, LO shifts dividend out and quotient in.
  assign div_shift = {acc_hi_i, acc_lo_i[31]};
  assign div_ge    = div_shift[32] || (div_shift[31:0] >= opnd_i);
  assign div_diff  = div_shift[31:0] - opnd_i;

  always_comb begin
    acc_hi_o = mul_sum[32:1];
    acc_lo_o = {mul_sum[0], acc_lo_i[31:1]};
    if (is_div_i) begin
      acc_hi_o = div_ge ? div_diff : div_shift[31:0];
      acc_lo_o = {acc_lo_i[30:0], div_ge};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; results land ITER+1 edges after start.
// While busy, any HI/LO access or new start from EX raises stall_req.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   acc_hi_q, acc_hi_d;
  logic [31:0]   acc_lo_q, acc_lo_d;
  logic [31:0]   opnd_q, opnd_d;
  logic          neg_p_q, neg_p_d;
  logic          neg_r_q, neg_r_d;
  logic          bzero_q, bzero_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  op_e         op_in;
  logic        sgn_a, sgn_b;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_mag, prod_fix;

  assign op_in = op_e'(op);
  assign sgn_a = op_is_signed(op_in) & src_a[31];
  assign sgn_b = op_is_signed(op_in) & src_b[31];

  muldiv_step u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_p_q ? (~prod_mag + 64'd1) : prod_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          op_d     = op_in;
          a_d      = src_a;
          acc_hi_d = 32'd0;
          acc_lo_d = mag32(src_a, sgn_a);
          opnd_d   = mag32(src_b, sgn_b);
          neg_p_d  = sgn_a ^ sgn_b;
          neg_r_d  = sgn_a;
          bzero_d  = (src_b == 32'd0);
          cnt_d    = CW'(ITER - 1);
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          if (cnt_q == '0) state_d = S_FIN;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!op_is_div(op_q)) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (bzero_q) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            hi_d = a_q;
            lo_d = DIV_ZERO_QUO;
          end else begin
            hi_d = mag32(acc_hi_q, neg_r_q);
            lo_d = mag32(acc_lo_q, neg_p_q);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      a_q      <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opnd_q   <= 32'd0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall_req = busy & (rd_req | start | hi_we | lo_we);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic reference model checked every cycle
// plus hand-computed literals for each directed vector.
module tb_ex_muldiv;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0, rd_req = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int total = 0, bad = 0;
  int cyc_cnt = 0, done_seen = 0, busy_cnt = 0;

  ex_muldiv #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .rd_req(rd_req),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    res = '0;
    case (o)
      2'd0: begin p = sa * sb; res = p; end
      2'd1: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Cycle model: m_rem counts edges until the result is architecturally visible.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem == 0) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start && !flush) begin
          {m_phi, m_plo} = model(op, src_a, src_b);
          m_rem = ITER + 1;
        end
      end else if (flush) begin
        m_rem = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_rem != 0));
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("stall_req", stall_req, (m_rem != 0) && (rd_req || start || hi_we || lo_we));
    if (done) done_seen++;
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int edge_n);
    @(posedge clk); #2;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    edge_n = cyc_cnt;
    busy_cnt = busy ? 1 : 0;
    #1;
    start = 1'b0; op = 2'($urandom_range(3)); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_done(input string name, input int edge_n);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    if (!done) chk({name, " done timeout"}, 32'd0, 32'd1);
    else chk({name, " latency"}, cyc_cnt - edge_n, ITER + 1);
  endtask

  task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int e;
    launch(o, a, b, e);
    wait_done(name, e);
    chk({name, " busy cycles"}, busy_cnt, ITER + 1);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
  endtask

  initial begin
    int e, d0;
    // Reset state; start/rd_req asserted during reset must not stall.
    #1; start = 1'b1; rd_req = 1'b1;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset stall", stall_req, 0);
    start = 1'b0; rd_req = 1'b0;
    @(posedge clk); #2; reset = 1'b0;

    run_vec("mult -2*3",       2'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_vec("div -7/2",        2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_vec("divu x/0",        2'd3, 32'h8000_0000, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF);
    run_vec("multu max*max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_vec("div min/-1",      2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_vec("div -7/0",        2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_vec("mult min*min",    2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_vec("divu 100/7",      2'd3, 32'd100,       32'd7,        32'd2,         32'd14);
    run_vec("mult 7*-3",       2'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_vec("div 7/-2",        2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

    // MFHI + MTHI while busy: stall, write ignored, result on time.
    launch(2'd0, 32'd5, 32'd6, e);
    repeat (4) @(posedge clk);
    #2; rd_req = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    #1; chk("busy access stall", stall_req, 1);
    @(posedge clk); #2; rd_req = 1'b0; hi_we = 1'b0;
    wait_done("mult 5*6 stalled", e);
    chk("mult 5*6 hi", hi, 32'd0);
    chk("mult 5*6 lo", lo, 32'd30);

    // MTHI/MTLO in IDLE, together and separately.
    @(posedge clk); #2; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
    @(posedge clk); #1; chk("mthi+mtlo hi", hi, 32'hA5A5_0001); chk("mthi+mtlo lo", lo, 32'hA5A5_0001);
    #1; lo_we = 1'b0; wdata = 32'h1111_1111;
    @(posedge clk); #2; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(posedge clk); #2; lo_we = 1'b0;
    chk("mthi hi", hi, 32'h1111_1111);
    chk("mtlo lo", lo, 32'h2222_2222);

    // start with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = 2'd2; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1; chk("flushed start busy", busy, 0);
    #1; start = 1'b0; flush = 1'b0;

    // Flush mid-divide.
    launch(2'd2, 32'd100, 32'd7, e);
    repeat (8) @(posedge clk);
    #2; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush busy", busy, 0);
    #1; flush = 1'b0;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    chk("flush no done", done_seen - d0, 0);
    chk("flush hi kept", hi, 32'h1111_1111);
    chk("flush lo kept", lo, 32'h2222_2222);

    // MTHI in the accepting cycle applies, then FIN overrides it.
    @(posedge clk); #2;
    start = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd4; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    e = cyc_cnt;
    chk("same-cycle mthi", hi, 32'hCAFE_F00D);
    #1; start = 1'b0; hi_we = 1'b0; src_a = $urandom; src_b = $urandom;
    wait_done("multu 3*4", e);
    chk("multu 3*4 hi", hi, 32'd0);
    chk("multu 3*4 lo", lo, 32'd12);

    // Reset mid-divide.
    launch(2'd2, 32'hFFFF_FFF9, 32'd2, e);
    repeat (8) @(posedge clk);
    #2; reset = 1'b1;
    #1;
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    @(posedge clk); #2; reset = 1'b0;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    chk("midreset no done", done_seen - d0, 0);
    run_vec("post-reset multu", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter ITER, default 32, giving the number of iteration cycles per operation.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: launch the operation on op/src_a/src_b.
REQ-005 SHALL have port op, input, 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have port src_a, input, 32: multiplicand or dividend, taken from the forwarded EX operand A.
REQ-007 SHALL have port src_b, input, 32: multiplier or divisor, taken from the forwarded EX operand B.
REQ-008 SHALL have port flush, input, 1: abort the operation in flight and suppress start.
REQ-009 SHALL have port hi_we, input, 1: MTHI write strobe.
REQ-010 SHALL have port lo_we, input, 1: MTLO write strobe.
REQ-011 SHALL have port wdata, input, 32: MTHI/MTLO write data.
REQ-012 SHALL have port rd_req, input, 1: MFHI/MFLO in EX.
REQ-013 SHALL have port busy, output, 1: operation in flight.
REQ-014 SHALL have port stall_req, output, 1: freeze PC, IF/ID and ID/EX this cycle.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when HI/LO are updated.
REQ-016 SHALL have port hi, output, 32: HI register.
REQ-017 SHALL have port lo, output, 32: LO register.

Function
REQ-018 SHALL implement three states: IDLE, RUN and FIN.
REQ-019 In IDLE, start=1 with flush=0 SHALL latch operands and op, load the counter with ITER-1, and enter RUN.
REQ-020 In IDLE, start=1 with flush=1 SHALL be ignored.
REQ-021 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide, on unsigned magnitudes.
REQ-022 RUN SHALL decrement the counter each step and enter FIN after the step at count 0.
REQ-023 FIN SHALL apply sign correction, write hi/lo, assert done for one cycle, and return to IDLE.
REQ-024 Latency SHALL be fixed: with start accepted at edge N, hi/lo and done become valid after edge N+ITER+1 (N+33 at the default).
REQ-025 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-026 stall_req SHALL equal busy & (rd_req | start | hi_we | lo_we), combinationally.
REQ-027 MULT/MULTU SHALL produce {hi,lo} = the 64-bit product; for MULT, signed product = sign(a)^sign(b).
REQ-028 DIV/DIVU SHALL produce lo = quotient and hi = remainder; for DIV, quotient sign = a^b and remainder sign = sign(a), truncating toward zero.
REQ-029 Divide by zero SHALL produce hi = src_a and lo = 0xFFFFFFFF for both DIV and DIVU, with the same latency.
REQ-030 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo = 0x80000000 and hi = 0.
REQ-031 The magnitude of 0x80000000 SHALL be handled as unsigned 2^31, with no overflow.
REQ-032 start while busy SHALL be ignored; the upstream stall holds the instruction until IDLE.
REQ-033 hi_we/lo_we in IDLE SHALL write wdata at the edge; both asserted SHALL write both registers.
REQ-034 hi_we/lo_we while busy SHALL be ignored (stalled).
REQ-035 hi_we/lo_we in the same IDLE cycle as an accepted start SHALL apply; the later FIN write overrides.
REQ-036 flush in RUN or FIN SHALL return to IDLE next edge, leave hi/lo unchanged, and keep done=0.
REQ-037 Operand latches SHALL be insensitive to src_a/src_b changes after acceptance.

Reset
REQ-038 reset SHALL force state IDLE, counter 0, hi=0, lo=0, done=0 and busy=0 asynchronously.
REQ-039 stall_req SHALL be 0 during reset.
REQ-040 Reset mid-operation SHALL discard the operation; the first start after reset deassertion SHALL behave as in REQ-019.

Structure
REQ-041 A shared package SHALL hold the op encodings, the state enum, and the ITER default.
REQ-042 The package SHALL hold the divide-by-zero constant 0xFFFFFFFF.
REQ-043 The block SHALL use one sub-module, muldiv_step: a combinational single-iteration add/subtract-shift datapath.
REQ-044 Control, counter, sign fixup and HI/LO SHALL reside in ex_muldiv.

Verification
REQ-045 MULT, a=0xFFFFFFFE (-2), b=3 -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 33 cycles.
REQ-046 DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-047 DIVU, a=0x80000000, b=0 -> hi=0x80000000, lo=0xFFFFFFFF at the normal latency.
REQ-048 MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-049 Start MULT, assert rd_req and hi_we at cycle 5 -> stall_req=1; hi_we ignored; result still written at start+33.
REQ-050 Start DIV, flush at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done.
REQ-051 Start DIV, reset at cycle 10 -> hi=lo=0, busy=0, no done.
